// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: round-robin grant over NCHAN requesters with a rotating priority pointer
module rr_arbiter #(
    parameter  int NCHAN = 4,
    localparam int CBITS = $clog2(NCHAN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCHAN-1:0] req,
    input  logic             en,
    output logic [NCHAN-1:0] gnt,
    output logic [CBITS-1:0] gnt_idx
);
    logic [CBITS-1:0] ptr_q, ptr_d;
    // first requester found searching upward from ptr, wrapping past the top channel
    always_comb begin
        logic found;
        int   j;
        found   = 1'b0;
        j       = 0;
        gnt     = '0;
        gnt_idx = '0;
        for (int k = 0; k < NCHAN; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NCHAN) j = j - NCHAN;
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = CBITS'(j);
            end
        end
    end
    // pointer moves just past the granted channel whenever a grant is consumed
    always_comb begin
        ptr_d = ptr_q;
        if (en) ptr_d = (gnt_idx == CBITS'(NCHAN - 1)) ? '0 : gnt_idx + CBITS'(1);
    end
    // pointer register
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux with round-robin or fixed selection and a registered output
module stream_mux_rr #(
    parameter  int NBITS = 8,
    parameter  int NCHAN = 4,
    localparam int CBITS = $clog2(NCHAN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCHAN-1:0]       in_val,
    output logic [NCHAN-1:0]       in_rdy,
    input  logic [NCHAN*NBITS-1:0] in_msg,
    input  logic                   fixed_en,
    input  logic [CBITS-1:0]       fixed_sel,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [NBITS-1:0]       out_msg,
    output logic [CBITS-1:0]       out_chan
);
    logic [NCHAN-1:0] rr_gnt;
    logic [CBITS-1:0] rr_idx;
    logic [CBITS-1:0] sel;
    logic             space;
    logic             xfer;
    logic             fixed_ok;
    logic             out_val_q, out_val_d;
    logic [NBITS-1:0] out_msg_q, out_msg_d;
    logic [CBITS-1:0] out_chan_q, out_chan_d;

    assign space    = !out_val_q || out_rdy;
    assign fixed_ok = int'(fixed_sel) < NCHAN;
    assign xfer     = |in_rdy;
    assign sel      = fixed_en ? fixed_sel : rr_idx;

    rr_arbiter #(.NCHAN(NCHAN)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_val),
        .en      (xfer && !fixed_en),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    // ready goes to at most one channel: the fixed one if valid, else the round-robin winner
    always_comb begin
        in_rdy = '0;
        if (!rst && space) begin
            if (fixed_en) begin
                if (fixed_ok && in_val[fixed_sel]) in_rdy[fixed_sel] = 1'b1;
            end else begin
                in_rdy = rr_gnt;
            end
        end
    end
    // load on input transfer (replacing any departing message), empty on a bare output transfer
    always_comb begin
        out_val_d  = out_val_q;
        out_msg_d  = out_msg_q;
        out_chan_d = out_chan_q;
        if (xfer) begin
            out_val_d  = 1'b1;
            out_msg_d  = in_msg[int'(sel)*NBITS +: NBITS];
            out_chan_d = sel;
        end else if (out_val_q && out_rdy) begin
            out_val_d  = 1'b0;
        end
    end
    // output register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_val_q  <= 1'b0;
            out_msg_q  <= '0;
            out_chan_q <= '0;
        end else begin
            out_val_q  <= out_val_d;
            out_msg_q  <= out_msg_d;
            out_chan_q <= out_chan_d;
        end
    end

    assign out_val  = out_val_q;
    assign out_msg  = out_msg_q;
    assign out_chan = out_chan_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: random and directed checks of 4- and 3-channel muxes against a behavioural model
module tb_stream_mux_rr;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_val;
    logic [31:0] in_msg;
    logic        fixed_en;
    logic [1:0]  fixed_sel;
    logic        out_rdy;
    logic [3:0]  rdy4;
    logic [2:0]  rdy3;
    logic        val4, val3;
    logic [7:0]  msg4, msg3;
    logic [1:0]  chan4, chan3;

    int checks = 0;
    int errors = 0;
    int nch[2] = '{4, 3};
    int m_ptr[2];
    bit m_ov[2];
    logic [7:0] m_om[2];
    int m_oc[2];
    int xfer4;

    always #5 clk = ~clk;

    stream_mux_rr #(.NBITS(8), .NCHAN(4)) dut4 (
        .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(rdy4), .in_msg(in_msg),
        .fixed_en(fixed_en), .fixed_sel(fixed_sel), .out_val(val4), .out_rdy(out_rdy),
        .out_msg(msg4), .out_chan(chan4)
    );

    stream_mux_rr #(.NBITS(8), .NCHAN(3)) dut3 (
        .clk(clk), .rst(rst), .in_val(in_val[2:0]), .in_rdy(rdy3), .in_msg(in_msg[23:0]),
        .fixed_en(fixed_en), .fixed_sel(fixed_sel), .out_val(val3), .out_rdy(out_rdy),
        .out_msg(msg3), .out_chan(chan3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(int d);
        int n = nch[d];
        if (fixed_en) return (int'(fixed_sel) < n && in_val[fixed_sel]) ? int'(fixed_sel) : -1;
        for (int k = 0; k < n; k++)
            if (in_val[(m_ptr[d] + k) % n]) return (m_ptr[d] + k) % n;
        return -1;
    endfunction

    // one clock: check ready against the model, advance the model across the edge, check outputs
    task automatic step();
        int g[2];
        bit acc[2];
        #1;
        for (int d = 0; d < 2; d++) begin
            g[d]   = pick(d);
            acc[d] = !rst && g[d] >= 0 && (!m_ov[d] || out_rdy);
        end
        check("rdy4", 32'(rdy4), acc[0] ? 32'(1) << g[0] : 32'd0);
        check("rdy3", 32'(rdy3), acc[1] ? 32'(1) << g[1] : 32'd0);
        xfer4 = acc[0] ? g[0] : -1;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_ov[d] = 0; m_om[d] = 0; m_oc[d] = 0; m_ptr[d] = 0;
            end else if (acc[d]) begin
                m_ov[d] = 1; m_om[d] = in_msg[g[d]*8 +: 8]; m_oc[d] = g[d];
                if (!fixed_en) m_ptr[d] = (g[d] + 1) % nch[d];
            end else if (m_ov[d] && out_rdy) begin
                m_ov[d] = 0;
            end
        end
        #1;
        check("val4", 32'(val4), 32'(m_ov[0]));
        check("msg4", 32'(msg4), 32'(m_om[0]));
        check("chan4", 32'(chan4), 32'(m_oc[0]));
        check("val3", 32'(val3), 32'(m_ov[1]));
        check("msg3", 32'(msg3), 32'(m_om[1]));
        check("chan3", 32'(chan3), 32'(m_oc[1]));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_val = '0; in_msg = '0; fixed_en = 1'b0; fixed_sel = '0; out_rdy = 1'b1;
        for (int d = 0; d < 2; d++) begin m_ptr[d] = 0; m_ov[d] = 0; m_om[d] = 0; m_oc[d] = 0; end
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;
        step();
        check("idle_val", 32'(val4), 32'd0);
        check("idle_msg", 32'(msg4), 32'd0);
        check("idle_rdy", 32'(rdy4), 32'd0);

        in_val = 4'b0100; in_msg = 32'h00A5_0000;
        step();
        check("single_msg", 32'(msg4), 32'hA5);
        check("single_chan", 32'(chan4), 32'd2);
        in_val = '0;
        step();

        do_reset();
        in_val = 4'b1111; in_msg = 32'h1312_1110;
        for (int i = 0; i < 8; i++) begin
            step();
            check("fair_chan", 32'(chan4), 32'(i % 4));
            check("fair_val", 32'(val4), 32'd1);
        end

        do_reset();
        step();
        step();
        check("bp_fill", 32'(msg4), 32'h11);
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_rdy", 32'(rdy4), 32'd0);
            check("bp_hold", 32'(msg4), 32'h11);
        end
        out_rdy = 1'b1;
        step();
        check("bp_resume", 32'(msg4), 32'h12);
        step();
        check("bp_ch3", 32'(chan4), 32'd3);

        fixed_en = 1'b1; fixed_sel = 2'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fixed_chan", 32'(chan4), 32'd3);
            check("fixed_none3", 32'(val3), 32'd0);
        end
        fixed_en = 1'b0;
        step();
        check("fixed_resume", 32'(chan4), 32'd0);

        do_reset();
        in_val = 4'b0100;
        step();
        check("wrap_ch2", 32'(chan3), 32'd2);
        in_val = 4'b0111;
        step();
        check("wrap_ch0", 32'(chan3), 32'd0);
        check("wrap_val", 32'(val3), 32'd1);
        in_val = '0; out_rdy = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_drop", 32'(val3), 32'd0);
        out_rdy = 1'b1;
        step();

        in_val = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!in_val[i] || xfer4 == i) begin
                    in_val[i] = 1'($urandom_range(0, 1));
                    in_msg[i*8 +: 8] = 8'($urandom);
                end
            end
            out_rdy = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 31) == 0) fixed_en = ~fixed_en;
            if ($urandom_range(0, 15) == 0) fixed_sel = 2'($urandom);
            rst = $urandom_range(0, 199) == 0;
            step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit stream multiplexer with a registered output, valid/ready handshakes on every channel, and round-robin or fixed channel selection. It extends our plain 2:1 combinational mux to arbitrary width and channel count. It adds back-pressure handling and fairness, and sits where several producers share one downstream consumer, such as result buses or shared functional units.

## Interface
- NBITS, 8, message width in bits (≥1)
- NCHAN, 4, number of input channels (≥2, need not be a power of two)
- CBITS, $clog2(NCHAN), channel-index width (derived localparam, not overridable)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_val  input  NCHAN  per-channel valid; bit i belongs to channel i
- in_rdy  output  NCHAN  per-channel ready; at most one bit high per cycle
- in_msg  input  NCHAN*NBITS  flattened messages; channel i is bits [i*NBITS +: NBITS]
- fixed_en  input  1  1 = fixed mode (serve only fixed_sel); 0 = round-robin mode
- fixed_sel  input  CBITS  channel served in fixed mode
- out_val  output  1  output register holds a valid message
- out_rdy  input  1  consumer ready
- out_msg  output  NBITS  registered message
- out_chan  output  CBITS  source channel of out_msg

## Operation
- **Output register:** a single entry holding out_val, out_msg and out_chan. "Space" means the register can take a new message this cycle: space = !out_val || out_rdy.
- **Output transfer:** occurs when out_val && out_rdy.
- **Input transfer on channel i:** occurs when in_val[i] && in_rdy[i].
- **Round-robin mode (fixed_en=0):**
  - The grant goes to the first channel with in_val set, searching upward from the priority pointer ptr and wrapping at NCHAN−1 to 0.
  - in_rdy[grant] = space. All other in_rdy bits are 0.
  - If no channel is valid, in_rdy is all zero.
- **Fixed mode (fixed_en=1):**
  - in_rdy[fixed_sel] = space && in_val[fixed_sel]. All other in_rdy bits are 0.
  - ptr is unchanged.
  - fixed_sel ≥ NCHAN means no grant.
- **On an input transfer:**
  - out_msg ← granted message, out_chan ← grant, out_val ← 1.
  - In round-robin mode, ptr ← grant+1, wrapping to 0 when grant = NCHAN−1.
- **Output transfer with no input transfer:** out_val ← 0. out_msg and out_chan hold their values.
- **Otherwise:** the register holds.
- **Simultaneous output and input transfer:** the new message replaces the old one in the same edge, so full throughput is one message per cycle.
- **Fairness:** with all NCHAN channels continuously valid and out_rdy=1, grants cycle 0,1,…,NCHAN−1,0,…
- **Reset:** out_val=0, out_msg=0, out_chan=0, ptr=0, in_rdy=0 during the reset cycle. A rst asserted mid-stream discards the held message, with no output transfer counted.
- **Mode changes:** a mode or fixed_sel change takes effect in the same cycle. A held message is never altered.

## Timing
- Latency: a message accepted at edge k appears on out_msg/out_val after edge k, so it is first visible in cycle k+1.
- in_rdy is combinational from in_val, ptr, fixed_en, fixed_sel, out_val and out_rdy.
- out_* are driven purely from registers, with no combinational path from inputs.
- Producer and consumer rules:
  - A producer must hold in_val and in_msg stable until its transfer.
  - The consumer may drop out_rdy at any time.
  - out_val and out_msg are stable while out_val && !out_rdy.
- Throughput is 1 message/cycle with out_rdy=1, and 0 while the register is full and out_rdy=0.

## Structure
- No shared package; CBITS is a localparam inside the module.
- Sub-module rr_arbiter (parameter NCHAN):
  - Inputs: clk, rst, req[NCHAN], en (the update strobe).
  - Outputs: one-hot gnt[NCHAN] and the encoded gnt_idx[CBITS].
  - Owns ptr; ptr updates only when en is high.
- The top level holds the fixed-mode override, the data mux (an indexed select on in_msg) and the output register.

## Test plan
- Reset then idle: rst=1 for 2 cycles, then in_val=0 → out_val=0, out_msg=0, out_chan=0, in_rdy=0000.
- Single channel, NCHAN=4, NBITS=8: in_val=0100, in_msg[2]=0xA5, out_rdy=1 → in_rdy=0100; next cycle out_val=1, out_msg=0xA5, out_chan=2.
- Fairness: all in_val=1111 with messages 0x10,0x11,0x12,0x13 and out_rdy=1 for 8 cycles → out_chan sequence 0,1,2,3,0,1,2,3 with no bubbles.
- Back-pressure: register full with 0x11 and out_rdy=0 for 3 cycles → in_rdy=0000 and out_msg held at 0x11. Raising out_rdy then accepts the next channel in the same cycle.
- Fixed mode: fixed_en=1, fixed_sel=3, in_val=1111 → only channel 3 is served every cycle and ptr is unchanged. Switching back to fixed_en=0 resumes from the old ptr.
- Non-power-of-two wrap and mid-stream reset: NCHAN=3, valid channels 2 then 0 → the pointer wraps 2→0. Asserting rst while out_val=1 → out_val=0 next cycle and the message is dropped.
